sd_read_arbiter: RTL and testbench



---
 rtl/sd_read_arbiter_pkg.sv | 16 +
 rtl/sd_read_arbiter_rr.sv | 36 +++
 rtl/sd_read_arbiter.sv | 130 +++++++++++++
 tb/tb_sd_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_read_arbiter_pkg.sv
// Shared constants for the SD block-read arbiter: block geometry, timeout default
// and the arbiter FSM state encodings.
package sd_read_arbiter_pkg;

  localparam int BLOCK_BITS_DEFAULT = 9;
  localparam int BLOCK_WIDTH        = 4096;
  localparam int TIMEOUT_DEFAULT    = 2**20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOOKUP    = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd4;
  localparam logic [2:0] ST_RESPOND   = 3'd5;

endpackage

// File: rtl/sd_read_arbiter_rr.sv
// Two-requester round-robin grant: on a tie the port that did not win last time
// is chosen; last_grant only moves when the owner reports a completed access.
module rr_arbiter2 (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic update_port,
  output logic grant,
  output logic valid
);

  logic last_grant;

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  assign valid = req0 | req1;

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_port;
    end
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one SD block-read controller between instruction fetch (port 0) and data
// load (port 1), with a one-block buffer so repeat reads of a block skip the card.
module sd_read_arbiter
  import sd_read_arbiter_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int BLOCK_BITS = BLOCK_BITS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0,
  input  logic [31:0]            addr0,
  output logic                   ack0,
  input  logic                   req1,
  input  logic [31:0]            addr1,
  output logic                   ack1,
  output logic [BLOCK_WIDTH-1:0] block_data,
  output logic                   error,
  output logic                   sd_rd_en,
  output logic [31:0]            sd_addr,
  input  logic [BLOCK_WIDTH-1:0] sd_read_data,
  input  logic                   sd_busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Handshake: req is a level held until the matching one-cycle ack; the ack cycle
  // is the only cycle block_data is guaranteed fresh for that port. To the
  // controller, sd_rd_en is held from Issue until busy falls (or timeout).
  logic [2:0]              state;
  logic                    grant_q;
  logic [31:0]             addr_q;
  logic [31-BLOCK_BITS:0]  tag;
  logic                    buf_valid;
  logic [CW-1:0]           count;

  logic arb_grant;
  logic arb_valid;
  logic hit;
  logic in_wait;
  logic done_now;
  logic timeout_now;
  logic respond_now;

  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .update      (respond_now),
    .update_port (grant_q),
    .grant       (arb_grant),
    .valid       (arb_valid)
  );

  assign hit         = buf_valid && (tag == addr_q[31:BLOCK_BITS]);
  assign in_wait     = (state == ST_WAIT_HIGH) || (state == ST_WAIT_LOW);
  assign done_now    = (state == ST_WAIT_LOW) && !sd_busy;
  assign timeout_now = in_wait && !done_now && (count == CW'(TIMEOUT - 1));

  // A timed-out access acks in its last waiting cycle so the FSM can go straight
  // back to Idle, where the requester has already lowered req.
  assign respond_now = (state == ST_RESPOND) || timeout_now;
  assign ack0        = respond_now && !grant_q;
  assign ack1        = respond_now && grant_q;
  assign error       = timeout_now;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      tag        <= '0;
      buf_valid  <= 1'b0;
      block_data <= '0;
      sd_rd_en   <= 1'b0;
      sd_addr    <= '0;
      count      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_grant;
            addr_q  <= arb_grant ? addr1 : addr0;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            state <= ST_RESPOND;
          end else begin
            sd_rd_en <= 1'b1;
            sd_addr  <= addr_q >> BLOCK_BITS;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          count <= '0;
          state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH, ST_WAIT_LOW: begin
          if (done_now) begin
            block_data <= sd_read_data;
            tag        <= addr_q[31:BLOCK_BITS];
            buf_valid  <= 1'b1;
            sd_rd_en   <= 1'b0;
            state      <= ST_RESPOND;
          end else if (timeout_now) begin
            // Leave block_data alone but distrust it for the next lookup.
            buf_valid <= 1'b0;
            sd_rd_en  <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            count <= count + 1'b1;
            if ((state == ST_WAIT_HIGH) && sd_busy) begin
              state <= ST_WAIT_LOW;
            end
          end
        end
        ST_RESPOND: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter with an SD controller model and an ack
// scoreboard holding {port, error, block_data} per expected response.
module tb_sd_read_arbiter;
  import sd_read_arbiter_pkg::*;

  localparam int TO = 64;
  localparam int BW = BLOCK_WIDTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [31:0]   addr0 = '0, addr1 = '0;
  logic          ack0, ack1, error, sd_rd_en, sd_busy;
  logic [BW-1:0] block_data, sd_read_data;
  logic [31:0]   sd_addr;

  always #5 clock = ~clock;

  sd_read_arbiter #(.TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0         (req0),
    .addr0        (addr0),
    .ack0         (ack0),
    .req1         (req1),
    .addr1        (addr1),
    .ack1         (ack1),
    .block_data   (block_data),
    .error        (error),
    .sd_rd_en     (sd_rd_en),
    .sd_addr      (sd_addr),
    .sd_read_data (sd_read_data),
    .sd_busy      (sd_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [BW-1:0] gen_block(input logic [31:0] blk);
    logic [BW-1:0] d;
    for (int i = 0; i < BW / 32; i++) begin
      d[i*32 +: 32] = {blk[15:0], 16'(i)} ^ 32'h5A5A_0000;
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // SD controller model: busy for busy_len cycles after it sees rd_en from Idle.
  int          busy_len   = 20;
  logic        never_done = 1'b0;
  logic        ctl_active;
  logic        armed;
  int          ctl_rem;
  logic [31:0] addr_log[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ctl_active   <= 1'b0;
      armed        <= 1'b1;
      ctl_rem      <= 0;
      sd_read_data <= '0;
    end else if (!sd_rd_en) begin
      ctl_active <= 1'b0;
      armed      <= 1'b1;
    end else if (!ctl_active && armed) begin
      ctl_active   <= 1'b1;
      armed        <= 1'b0;
      ctl_rem      <= busy_len;
      sd_read_data <= gen_block(sd_addr);
      addr_log.push_back(sd_addr);
    end else if (ctl_active && !never_done) begin
      if (ctl_rem <= 1) ctl_active <= 1'b0;
      else ctl_rem <= ctl_rem - 1;
    end
  end

  assign sd_busy = ctl_active && sd_rd_en;

  int rd_hi = 0;
  always @(negedge clock) if (sd_rd_en) rd_hi++;

  // Scoreboard monitor.
  logic [BW+1:0] exp_q[$];
  logic [BW+1:0] exp_e;

  always @(negedge clock) begin
    if (!reset) begin
      if (error && !(ack0 || ack1)) check("error_without_ack", 64'(error), 64'd0);
      if (ack0 || ack1) begin
        if (ack0 && ack1) begin
          check("ack_both", 64'({ack0, ack1}), 64'd1);
        end else if (exp_q.size() == 0) begin
          check("sb_unexpected_ack", 64'({ack0, ack1}), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("sb_port_error", 64'({ack1, error}), 64'(exp_e[BW+1:BW]));
          n_checks++;
          if (block_data !== exp_e[BW-1:0]) begin
            n_fail++;
            $display("FAIL sb_block_data: got low64 %h required low64 %h",
                     block_data[63:0], exp_e[63:0]);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic err, input logic [31:0] blk);
    exp_q.push_back({port, err, gen_block(blk)});
  endtask

  task automatic wait_ack(input int port, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    if (!got) check("ack_wait_expired", 64'(port), 64'hFF);
  endtask

  task automatic run_port(input int port, input logic [31:0] a, output int lat);
    @(posedge clock); #1;
    if (port == 0) begin addr0 = a; req0 = 1'b1; end
    else begin addr1 = a; req1 = 1'b1; end
    wait_ack(port, lat);
    @(posedge clock); #1;
    if (port == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, 64'(ack0), 64'd0);
    check({tag, "_ack1"}, 64'(ack1), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_sd_rd_en"}, 64'(sd_rd_en), 64'd0);
    check({tag, "_sd_addr"}, 64'(sd_addr), 64'd0);
    check({tag, "_block_data"}, 64'(|block_data), 64'd0);
  endtask

  int lat, l0, l1, base, gap;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Contention from reset: alternation 0,1,0,1 on blocks 0 and 1.
    base = addr_log.size();
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b1, 1'b0, 32'd1);
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b1, 1'b0, 32'd1);
    fork
      begin run_port(0, 32'h0000_0000, l0); run_port(0, 32'h0000_0000, l0); end
      begin run_port(1, 32'h0000_0200, l1); run_port(1, 32'h0000_0200, l1); end
    join
    check("contend_count", 64'(addr_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) check("contend_sd_addr", 64'(addr_log[base + i]), 64'(i % 2));

    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset2");
    reset = 1'b0;

    // Single miss, block 2, 20 busy cycles.
    base  = addr_log.size();
    rd_hi = 0;
    push_exp(1'b0, 1'b0, 32'd2);
    run_port(0, 32'h0000_0400, lat);
    check("miss_latency", 64'(lat), 64'd24);
    check("miss_rd_en_cycles", 64'(rd_hi), 64'd22);
    check("miss_count", 64'(addr_log.size() - base), 64'd1);
    check("miss_sd_addr", 64'(addr_log[base]), 64'd2);

    // Hit on the same block from port 1.
    base  = addr_log.size();
    rd_hi = 0;
    push_exp(1'b1, 1'b0, 32'd2);
    run_port(1, 32'h0000_05FC, lat);
    check("hit_latency", 64'(lat), 64'd2);
    check("hit_rd_en_cycles", 64'(rd_hi), 64'd0);
    check("hit_count", 64'(addr_log.size() - base), 64'd0);

    // Timeout on block 3: buffer keeps block 2 data but is invalidated.
    never_done = 1'b1;
    base  = addr_log.size();
    rd_hi = 0;
    push_exp(1'b0, 1'b1, 32'd2);
    run_port(0, 32'h0000_0600, lat);
    check("timeout_latency", 64'(lat), 64'd66);
    check("timeout_rd_en_cycles", 64'(rd_hi), 64'd65);
    check("timeout_sd_addr", 64'(addr_log[base]), 64'd3);
    never_done = 1'b0;
    push_exp(1'b1, 1'b0, 32'd2);
    run_port(1, 32'h0000_0400, lat);
    check("after_timeout_latency", 64'(lat), 64'd24);
    check("after_timeout_count", 64'(addr_log.size() - base), 64'd2);

    // Reset while waiting for busy to fall.
    @(posedge clock); #1;
    addr1 = 32'h0000_0E00;
    req1  = 1'b1;
    for (int i = 0; i < 50 && !sd_busy; i++) @(negedge clock);
    check("midreset_busy_seen", 64'(sd_busy), 64'd1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    req1 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    base  = addr_log.size();
    push_exp(1'b1, 1'b0, 32'd2);
    run_port(1, 32'h0000_0400, lat);
    check("postreset_latency", 64'(lat), 64'd24);
    check("postreset_count", 64'(addr_log.size() - base), 64'd1);

    // Stream: port 1 reads blocks 0..7 holding req and advancing the address.
    base = addr_log.size();
    for (int b = 0; b < 8; b++) push_exp(1'b1, 1'b0, 32'(b));
    @(posedge clock); #1;
    addr1 = 32'h0;
    req1  = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wait_ack(1, lat);
      @(posedge clock); #1;
      if (b < 7) begin
        addr1 = 32'(b + 1) << 9;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          if (sd_rd_en) break;
          gap++;
        end
        check("stream_gap", 64'(gap), 64'd2);
      end else begin
        req1 = 1'b0;
      end
    end
    check("stream_count", 64'(addr_log.size() - base), 64'd8);
    for (int b = 0; b < 8; b++) check("stream_sd_addr", 64'(addr_log[base + b]), 64'(b));

    repeat (5) @(negedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got time %0t required end before 500000", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
